lsb_queue: RTL

Parametrised load/store buffer between the decoder/issue stage and the data cache. Holds up to DEPTH memory instructions in program order and captures missing operands from the RS broadcast and its own load-result broadcast. It sends one request at a time to the cache: loads leave as soon as the head entry is ready, stores only when the ROB head points at them. This generation adds configurable depth and ROB-id width, a registered request/accept/done handshake, and a flush-safe drain of an in-flight cache access.

---
 rtl/lsb_queue.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/lsb_queue.sv
// Load/store buffer: in-order circular queue of memory ops feeding a single-outstanding cache port.
// Define LSB_ISSUE_BYPASS_EN to let an enqueuing entry capture same-cycle broadcasts.
module lsb_queue #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  output logic             lsb_full,
  input  logic             issue_valid,
  input  logic             issue_is_load,
  input  logic [2:0]       issue_op,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_v1,
  input  logic [31:0]      issue_v2,
  input  logic             issue_dep1,
  input  logic             issue_dep2,
  input  logic [ROB_W-1:0] issue_q1,
  input  logic [ROB_W-1:0] issue_q2,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob_id,
  input  logic [31:0]      cdb_value,
  input  logic             rob_clear,
  input  logic [ROB_W-1:0] rob_head_id,
  output logic             mem_req_valid,
  output logic             mem_req_is_load,
  output logic [2:0]       mem_req_op,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_data,
  input  logic             mem_req_accept,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             res_valid,
  output logic [ROB_W-1:0] res_rob_id,
  output logic [31:0]      res_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;

  typedef struct packed {
    logic             is_load;
    logic [2:0]       op;
    logic [31:0]      imm;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic             dep1;
    logic             dep2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] rob_id;
  } entry_t;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q;
  logic             req_valid_q, req_is_load_q;
  logic [2:0]       req_op_q;
  logic [31:0]      req_addr_q, req_data_q;
  logic [ROB_W-1:0] req_rob_id_q;
  logic             res_valid_q;
  logic [ROB_W-1:0] res_rob_id_q;
  logic [31:0]      res_value_q;

  logic             vld_w [DEPTH];
  entry_t           ent_w [DEPTH];
  entry_t           head_ent;
  entry_t           issue_ent;
  logic             head_ok, enq, deq;

  // Returns {dep, value} after matching a pending operand against both broadcast buses.
  function automatic logic [32:0] resolve(input logic dep, input logic [ROB_W-1:0] q,
                                          input logic [31:0] val);
    if (dep && cdb_valid && cdb_rob_id == q) return {1'b0, cdb_value};
    if (dep && res_valid_q && res_rob_id_q == q) return {1'b0, res_value_q};
    return {dep, val};
  endfunction

  always_comb begin
    issue_ent         = '0;
    issue_ent.is_load = issue_is_load;
    issue_ent.op      = issue_op;
    issue_ent.imm     = issue_imm;
    issue_ent.v1      = issue_v1;
    issue_ent.v2      = issue_v2;
    issue_ent.dep1    = issue_dep1;
    issue_ent.dep2    = issue_dep2;
    issue_ent.q1      = issue_q1;
    issue_ent.q2      = issue_q2;
    issue_ent.rob_id  = issue_rob_id;
`ifdef LSB_ISSUE_BYPASS_EN
    {issue_ent.dep1, issue_ent.v1} = resolve(issue_dep1, issue_q1, issue_v1);
    {issue_ent.dep2, issue_ent.v2} = resolve(issue_dep2, issue_q2, issue_v2);
`endif
  end

  assign head_ent = ent_w[head_q];
  assign head_ok  = vld_w[head_q] && !head_ent.dep1 && !head_ent.dep2 &&
                    (head_ent.is_load || head_ent.rob_id == rob_head_id);
  assign enq      = rdy && issue_valid && !rob_clear;
  assign deq      = rdy && !rob_clear && state_q == ST_IDLE && head_ok;
  assign count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    entry_t ent_q;
    logic   vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        ent_q <= '0;
      end else if (rdy) begin
        if (rob_clear) begin
          vld_q <= 1'b0;
        end else if (enq && tail_q == PTR_W'(gi)) begin
          vld_q <= 1'b1;
          ent_q <= issue_ent;
        end else if (vld_q) begin
          if (deq && head_q == PTR_W'(gi)) vld_q <= 1'b0;
          {ent_q.dep1, ent_q.v1} <= resolve(ent_q.dep1, ent_q.q1, ent_q.v1);
          {ent_q.dep2, ent_q.v2} <= resolve(ent_q.dep2, ent_q.q2, ent_q.v2);
        end
      end
    end

    assign vld_w[gi] = vld_q;
    assign ent_w[gi] = ent_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      req_valid_q   <= 1'b0;
      req_is_load_q <= 1'b0;
      req_op_q      <= '0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      req_rob_id_q  <= '0;
      res_valid_q   <= 1'b0;
      res_rob_id_q  <= '0;
      res_value_q   <= '0;
    end else if (rdy) begin
      res_valid_q <= 1'b0;
      if (rob_clear) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (enq) tail_q <= tail_q + PTR_W'(1);
        if (deq) head_q <= head_q + PTR_W'(1);
        count_q <= count_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (deq) begin
            req_valid_q   <= 1'b1;
            req_is_load_q <= head_ent.is_load;
            req_op_q      <= head_ent.op;
            req_addr_q    <= head_ent.v1 + head_ent.imm;
            req_data_q    <= head_ent.is_load ? 32'd0 : head_ent.v2;
            req_rob_id_q  <= head_ent.rob_id;
            state_q       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_accept) begin
            req_valid_q <= 1'b0;
            state_q     <= rob_clear ? ST_DRAIN : ST_WAIT;
          end else if (rob_clear) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_WAIT: begin
          // A flush coinciding with completion simply drops the result.
          if (mem_done) begin
            state_q <= ST_IDLE;
            if (!rob_clear) begin
              res_valid_q  <= 1'b1;
              res_rob_id_q <= req_rob_id_q;
              res_value_q  <= req_is_load_q ? mem_rdata : 32'd0;
            end
          end else if (rob_clear) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_req_accept) req_valid_q <= 1'b0;
          if (mem_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lsb_full        = (count_q == CNT_W'(DEPTH));
  assign mem_req_valid   = req_valid_q;
  assign mem_req_is_load = req_is_load_q;
  assign mem_req_op      = req_op_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_req_data    = req_data_q;
  assign res_valid       = res_valid_q;
  assign res_rob_id      = res_rob_id_q;
  assign res_value       = res_value_q;

endmodule
